// File: rtl/datapath_trace_buffer.sv
// Trace buffer for the LEGv8 datapath. It records register-file and data-memory
// writes with their PC into a circular buffer, with a PC trigger and a valid/ready readout.
// Ports: clock/reset; capture control enable, mode, clear, arm, trig_pc;
//   snoop inputs pc, reg_we/reg_da/reg_data, mem_we/mem_addr/mem_data;
//   readout rd_ready in, rd_valid/rd_kind/rd_tag/rd_value/rd_pc out;
//   status count, overflow, dropped, triggered, frozen.
module datapath_trace_buffer #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic              clear,
  input  logic              arm,
  input  logic [ADDR_W-1:0] trig_pc,
  input  logic [ADDR_W-1:0] pc,
  input  logic              reg_we,
  input  logic [4:0]        reg_da,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [1:0]        rd_kind,
  output logic [ADDR_W-1:0] rd_tag,
  output logic [DATA_W-1:0] rd_value,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic [7:0]        dropped,
  output logic              triggered,
  output logic              frozen
);

  localparam int PW  = $clog2(DEPTH);
  localparam int PTW = $clog2(POST_TRIG + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_POST,
    S_FROZEN
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PTW-1:0]   post_q, post_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;
  logic             trg_q, trg_d;

  logic [1:0]        kind_q [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [DATA_W-1:0] val_q  [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  // Slot 0 is the register event, slot 1 the memory event (older first).
  logic [1:0]             ev;
  logic [1:0][1:0]        ev_kind;
  logic [1:0][ADDR_W-1:0] ev_tag;
  logic [1:0][DATA_W-1:0] ev_val;
  logic [1:0]             wen;
  logic [1:0][PW-1:0]     widx;
  logic                   pop;

  assign ev[0]      = reg_we && (reg_da != 5'd31);
  assign ev[1]      = mem_we;
  assign ev_kind[0] = 2'b01;
  assign ev_kind[1] = 2'b10;
  assign ev_tag[0]  = {{(ADDR_W-5){1'b0}}, reg_da};
  assign ev_tag[1]  = mem_addr;
  assign ev_val[0]  = reg_data;
  assign ev_val[1]  = mem_data;

  assign rd_valid = (cnt_q != '0);
  assign pop      = rd_valid && rd_ready;

  always_comb begin
    state_d = state_q;
    rp_d    = rp_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    post_d  = post_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    trg_d   = trg_q;
    wen     = '0;
    widx    = '0;
    if (clear) begin
      rp_d    = '0;
      wp_d    = '0;
      cnt_d   = '0;
      post_d  = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
      trg_d   = 1'b0;
      state_d = enable ? S_RUN : S_IDLE;
    end else begin
      // Pop first so a full buffer frees a slot for this cycle's push.
      if (pop) begin
        rp_d  = rp_d + PW'(1);
        cnt_d = cnt_d - CW'(1);
      end
      case (state_q)
        S_IDLE: if (enable) state_d = S_RUN;
        S_FROZEN: ;
        default: begin
          if (!enable) begin
            state_d = S_IDLE;
          end else begin
            if (state_q == S_RUN && arm && pc == trig_pc && ev != '0) begin
              state_d = S_POST;
              trg_d   = 1'b1;
              post_d  = PTW'(POST_TRIG);
            end
            for (int k = 0; k < 2; k++) begin
              if (ev[k] && state_d != S_FROZEN) begin
                if (cnt_d == CW'(DEPTH) && mode) begin
                  if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
                end else begin
                  wen[k]  = 1'b1;
                  widx[k] = wp_d;
                  wp_d    = wp_d + PW'(1);
                  if (cnt_d == CW'(DEPTH)) begin
                    rp_d  = rp_d + PW'(1);
                    ovf_d = 1'b1;
                  end else begin
                    cnt_d = cnt_d + CW'(1);
                  end
                  if (state_d == S_POST) begin
                    post_d = post_d - PTW'(1);
                    if (post_d == '0) state_d = S_FROZEN;
                  end
                end
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rp_q    <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      post_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      trg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      post_q  <= post_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      trg_q   <= trg_d;
    end
  end

  // Entry storage needs no reset; the readout is gated by rd_valid.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (wen[k]) begin
        kind_q[widx[k]] <= ev_kind[k];
        tag_q[widx[k]]  <= ev_tag[k];
        val_q[widx[k]]  <= ev_val[k];
        pc_q[widx[k]]   <= pc;
      end
    end
  end

  assign rd_kind   = rd_valid ? kind_q[rp_q] : '0;
  assign rd_tag    = rd_valid ? tag_q[rp_q]  : '0;
  assign rd_value  = rd_valid ? val_q[rp_q]  : '0;
  assign rd_pc     = rd_valid ? pc_q[rp_q]   : '0;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign dropped   = drop_q;
  assign triggered = trg_q;
  assign frozen    = (state_q == S_FROZEN);

endmodule
